tta_icache: RTL and testbench
=============================

TTA_ICACHE -- requirements
Module: tta_icache

Interface
REQ-001 The module SHALL declare parameter AW, default 16, instruction address width.
REQ-002 The module SHALL declare parameter IW, default 32, instruction word width.
REQ-003 The module SHALL declare parameter WBITS, default 4, log2 words per line.
REQ-004 The module SHALL declare parameter LBITS, default 2, log2 lines; direct-mapped.
REQ-005 The module SHALL declare parameter PREFETCH, default 1, next-line prefetch enable.
REQ-006 The module SHALL have one clock, clock_i, and a synchronous, active-low reset, reset_ni.
REQ-007 The module SHALL provide these ports:
- clock_i  in  1  clock
- reset_ni  in  1  synchronous active-low reset
- pc_i  in  AW  fetch word address
- hit_o  out  1  instr_o valid for pc_i
- instr_o  out  IW  instruction word
- flush_i  in  1  invalidate all lines
- ifetch_o  out  1  line fetch request to L1
- iabort_o  out  1  abort current L1 fetch
- iready_i  in  1  idata_i valid, one word per pulse
- iaddr_o  out  AW  line base address, low WBITS bits zero
- idata_i  in  IW  fill word

Function
REQ-008 Address split SHALL be: word=pc_i[WBITS-1:0]; index=pc_i[WBITS+LBITS-1:WBITS]; tag=remaining upper bits.
REQ-009 hit_o SHALL be combinational from pc_i and registered state, asserted in either case:
- valid[index] and tag match
- pc_i is in the line being filled and word < fill count
REQ-010 instr_o SHALL be the addressed word when hit_o=1, and all-zero otherwise.
REQ-011 The FSM SHALL have the states IDLE, FILL and PREF.
REQ-012 In IDLE, on hit_o=0 the FSM SHALL, next cycle:
- register iaddr_o = pc_i line base
- clear valid[index] and set ifetch_o=1
- clear count and enter FILL
REQ-013 In FILL/PREF, each iready_i=1 SHALL write idata_i to word count of the target line, then count increments by 1.
REQ-014 ifetch_o SHALL stay 1 throughout FILL/PREF and drop the cycle after the last-word iready_i.
REQ-015 On the last word (count=2^WBITS-1 with iready_i), valid and tag SHALL be set.
REQ-016 After the last word of FILL, if PREFETCH=1 and the next line is not valid, the FSM SHALL enter PREF; otherwise it SHALL enter IDLE.
REQ-017 PREF SHALL fetch the next line (iaddr_o + 2^WBITS, modulo 2^AW) without a gap cycle.
REQ-018 In FILL/PREF, if pc_i misses and lies outside the target line, the block SHALL:
- pulse iabort_o for 1 cycle and drop ifetch_o that cycle
- leave the partial line invalid and enter IDLE
- issue the demand fetch per REQ-012 on the following cycle
REQ-019 If iready_i coincides with the abort or flush cycle, the word SHALL be discarded.
REQ-020 In IDLE, flush_i SHALL clear all valid bits with no iabort_o.
REQ-021 In FILL/PREF, flush_i SHALL clear all valid bits, pulse iabort_o and enter IDLE.
REQ-022 iready_i SHALL be ignored in IDLE.
REQ-023 The count width SHALL be WBITS; the increment after the last word SHALL wrap count to 0.

Reset
REQ-024 While reset_ni=0 at a clock edge, the block SHALL enter IDLE with:
- all valid bits cleared
- count=0
- iaddr_o=0, ifetch_o=0, iabort_o=0
- hit_o=0, instr_o=0 as consequence
REQ-025 Reset during FILL/PREF SHALL abandon the fetch silently, with no iabort_o pulse.

Verification
REQ-026 Cold miss: after reset, pc_i=0x0123 -> ifetch_o=1 and iaddr_o=0x0120 next cycle; 16 iready_i pulses -> ifetch_o drops; then PREF with iaddr_o=0x0130.
REQ-027 Early hit: during the fill of 0x0120, after 4 words, pc_i=0x0122 -> hit_o=1 and instr_o = word 2; pc_i=0x0125 -> hit_o=0.
REQ-028 Branch abort: in PREF of 0x0130, pc_i=0x0800 -> 1-cycle iabort_o, then ifetch_o with iaddr_o=0x0800; line 0x0130 stays invalid.
REQ-029 Conflict eviction: line 0x0120 valid, then pc_i=0x0520 (same index) -> miss and refill; afterwards pc_i=0x0120 -> hit_o=0.
REQ-030 Flush and wrap:
- flush_i in IDLE with all lines valid -> hit_o=0 for every previously cached pc_i
- fill of 0xFFF0 with PREFETCH=1 -> PREF iaddr_o=0x0000
REQ-031 Reset mid-FILL after 7 words -> iaddr_o=0, ifetch_o=0 and no iabort_o; the same pc_i then refetches from word 0.

Source files
------------

// File: rtl/tta_icache.sv
// Direct-mapped instruction cache with word-granular early hit during line fill
// and optional next-line prefetch; fills arrive one word per iready_i pulse.
module tta_icache #(
    parameter int AW       = 16,
    parameter int IW       = 32,
    parameter int WBITS    = 4,
    parameter int LBITS    = 2,
    parameter int PREFETCH = 1
) (
    input  logic          clock_i,
    input  logic          reset_ni,
    input  logic [AW-1:0] pc_i,
    output logic          hit_o,
    output logic [IW-1:0] instr_o,
    input  logic          flush_i,
    output logic          ifetch_o,
    output logic          iabort_o,
    input  logic          iready_i,
    output logic [AW-1:0] iaddr_o,
    input  logic [IW-1:0] idata_i
);

    localparam int NW = 1 << WBITS;
    localparam int NL = 1 << LBITS;
    localparam int TW = AW - WBITS - LBITS;
    localparam int LW = AW - WBITS;
    localparam logic [WBITS-1:0] CNT_ONE  = 1;
    localparam logic [LW-1:0]    LINE_ONE = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PREF = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [NL-1:0]    valid_q, valid_d;
    logic [WBITS-1:0] count_q, count_d;
    logic [AW-1:0]    iaddr_q, iaddr_d;
    logic             ifetch_q, ifetch_d;
    logic             iabort_q, iabort_d;
    logic [TW-1:0]    tag_q [NL];
    logic [IW-1:0]    mem_q [NL*NW];

    logic             wr_en;
    logic             tag_wr;

    logic [WBITS-1:0] pc_word;
    logic [LBITS-1:0] pc_index;
    logic [TW-1:0]    pc_tag;
    logic [LW-1:0]    pc_line;
    logic [LW-1:0]    tgt_line;
    logic [LBITS-1:0] tgt_index;
    logic [TW-1:0]    tgt_tag;
    logic [LW-1:0]    next_line;
    logic [LBITS-1:0] next_index;
    logic [TW-1:0]    next_tag;
    logic             busy;
    logic             cache_hit;
    logic             fill_hit;
    logic             next_cached;
    logic             leave_line;

    assign pc_word    = pc_i[WBITS-1:0];
    assign pc_index   = pc_i[WBITS+LBITS-1:WBITS];
    assign pc_tag     = pc_i[AW-1:WBITS+LBITS];
    assign pc_line    = pc_i[AW-1:WBITS];
    assign tgt_line   = iaddr_q[AW-1:WBITS];
    assign tgt_index  = iaddr_q[WBITS+LBITS-1:WBITS];
    assign tgt_tag    = iaddr_q[AW-1:WBITS+LBITS];
    assign next_line  = tgt_line + LINE_ONE;
    assign next_index = next_line[LBITS-1:0];
    assign next_tag   = next_line[LW-1:LBITS];

    assign busy        = (state_q != IDLE);
    assign cache_hit   = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
    // Words already delivered for the line in flight are usable before the line is marked valid.
    assign fill_hit    = busy && (pc_line == tgt_line) && (pc_word < count_q);
    assign hit_o       = cache_hit || fill_hit;
    assign instr_o     = hit_o ? mem_q[{pc_index, pc_word}] : '0;
    assign next_cached = valid_q[next_index] && (tag_q[next_index] == next_tag);
    assign leave_line  = !hit_o && (pc_line != tgt_line);

    assign iaddr_o  = iaddr_q;
    assign ifetch_o = ifetch_q;
    assign iabort_o = iabort_q;

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        count_d  = count_q;
        iaddr_d  = iaddr_q;
        ifetch_d = ifetch_q;
        iabort_d = 1'b0;
        wr_en    = 1'b0;
        tag_wr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    valid_d = '0;
                end else if (!hit_o) begin
                    iaddr_d           = {pc_line, {WBITS{1'b0}}};
                    valid_d[pc_index] = 1'b0;
                    ifetch_d          = 1'b1;
                    count_d           = '0;
                    state_d           = FILL;
                end
            end
            FILL, PREF: begin
                // Abort/flush wins over a coincident fill word, which is dropped.
                if (flush_i || leave_line) begin
                    if (flush_i) begin
                        valid_d = '0;
                    end
                    iabort_d = 1'b1;
                    ifetch_d = 1'b0;
                    count_d  = '0;
                    state_d  = IDLE;
                end else if (iready_i) begin
                    wr_en   = 1'b1;
                    count_d = count_q + CNT_ONE;
                    if (count_q == '1) begin
                        valid_d[tgt_index] = 1'b1;
                        tag_wr             = 1'b1;
                        if ((state_q == FILL) && (PREFETCH != 0) && !next_cached) begin
                            iaddr_d             = {next_line, {WBITS{1'b0}}};
                            valid_d[next_index] = 1'b0;
                            state_d             = PREF;
                        end else begin
                            ifetch_d = 1'b0;
                            state_d  = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                ifetch_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state_q  <= IDLE;
            valid_q  <= '0;
            count_q  <= '0;
            iaddr_q  <= '0;
            ifetch_q <= 1'b0;
            iabort_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
            iaddr_q  <= iaddr_d;
            ifetch_q <= ifetch_d;
            iabort_q <= iabort_d;
        end
    end

    // Data and tag storage need no reset; valid_q gates every use.
    always_ff @(posedge clock_i) begin
        if (reset_ni && wr_en) begin
            mem_q[{tgt_index, count_q}] <= idata_i;
        end
        if (reset_ni && tag_wr) begin
            tag_q[tgt_index] <= tgt_tag;
        end
    end

endmodule

// File: tb/tb_tta_icache.sv
// Directed bench for tta_icache: fill, early hit, prefetch, abort, eviction, flush, wrap, reset.
module tb_tta_icache;

    logic        clock_i;
    logic        reset_ni;
    logic [15:0] pc_i;
    logic        hit_o;
    logic [31:0] instr_o;
    logic        flush_i;
    logic        ifetch_o;
    logic        iabort_o;
    logic        iready_i;
    logic [15:0] iaddr_o;
    logic [31:0] idata_i;

    int n_vec = 0;
    int n_err = 0;

    tta_icache #(
        .AW(16), .IW(32), .WBITS(4), .LBITS(2), .PREFETCH(1)
    ) dut (
        .clock_i (clock_i),
        .reset_ni(reset_ni),
        .pc_i    (pc_i),
        .hit_o   (hit_o),
        .instr_o (instr_o),
        .flush_i (flush_i),
        .ifetch_o(ifetch_o),
        .iabort_o(iabort_o),
        .iready_i(iready_i),
        .iaddr_o (iaddr_o),
        .idata_i (idata_i)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    // L1 content: each word carries its own address in the low half.
    function automatic logic [31:0] dval(input logic [15:0] a);
        return {16'hC0DE, a};
    endfunction

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic feed(input logic [15:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            iready_i = 1'b1;
            idata_i  = dval(base + 16'(k));
            step();
        end
        iready_i = 1'b0;
        idata_i  = '0;
    endtask

    task automatic test_reset();
        reset_ni = 1'b0;
        pc_i     = 16'h0123;
        step();
        step();
        n_vec++; if (ifetch_o !== 1'b0) begin n_err++; $display("FAIL rst_ifetch got %0b want 0", ifetch_o); end
        n_vec++; if (iabort_o !== 1'b0) begin n_err++; $display("FAIL rst_iabort got %0b want 0", iabort_o); end
        n_vec++; if (iaddr_o !== 16'h0000) begin n_err++; $display("FAIL rst_iaddr got %h want 0000", iaddr_o); end
        n_vec++; if (hit_o !== 1'b0) begin n_err++; $display("FAIL rst_hit got %0b want 0", hit_o); end
        n_vec++; if (instr_o !== 32'h0) begin n_err++; $display("FAIL rst_instr got %h want 0", instr_o); end
    endtask

    task automatic test_cold_miss();
        reset_ni = 1'b1;
        step();
        n_vec++; if (ifetch_o !== 1'b1) begin n_err++; $display("FAIL cold_ifetch got %0b want 1", ifetch_o); end
        n_vec++; if (iaddr_o !== 16'h0120) begin n_err++; $display("FAIL cold_iaddr got %h want 0120", iaddr_o); end
        feed(16'h0120, 4);
        pc_i = 16'h0122; #1;
        n_vec++; if (hit_o !== 1'b1) begin n_err++; $display("FAIL early_hit got %0b want 1", hit_o); end
        n_vec++; if (instr_o !== 32'hC0DE0122) begin n_err++; $display("FAIL early_instr got %h want C0DE0122", instr_o); end
        pc_i = 16'h0125; #1;
        n_vec++; if (hit_o !== 1'b0) begin n_err++; $display("FAIL early_nohit got %0b want 0", hit_o); end
        n_vec++; if (instr_o !== 32'h0) begin n_err++; $display("FAIL early_instr0 got %h want 0", instr_o); end
        pc_i = 16'h0123;
        feed(16'h0124, 12);
        n_vec++; if (iaddr_o !== 16'h0130) begin n_err++; $display("FAIL pref_iaddr got %h want 0130", iaddr_o); end
        n_vec++; if (ifetch_o !== 1'b1) begin n_err++; $display("FAIL pref_ifetch got %0b want 1", ifetch_o); end
        n_vec++; if (hit_o !== 1'b1 || instr_o !== 32'hC0DE0123) begin n_err++; $display("FAIL line_valid got %0b/%h want 1/C0DE0123", hit_o, instr_o); end
    endtask

    task automatic test_branch_abort();
        feed(16'h0130, 2);
        pc_i     = 16'h0800;
        iready_i = 1'b1;
        idata_i  = dval(16'h0132);
        step();
        iready_i = 1'b0;
        n_vec++; if (iabort_o !== 1'b1) begin n_err++; $display("FAIL abort_pulse got %0b want 1", iabort_o); end
        n_vec++; if (ifetch_o !== 1'b0) begin n_err++; $display("FAIL abort_ifetch got %0b want 0", ifetch_o); end
        step();
        n_vec++; if (iabort_o !== 1'b0) begin n_err++; $display("FAIL abort_width got %0b want 0", iabort_o); end
        n_vec++; if (ifetch_o !== 1'b1 || iaddr_o !== 16'h0800) begin n_err++; $display("FAIL abort_refetch got %0b/%h want 1/0800", ifetch_o, iaddr_o); end
        pc_i = 16'h0130; #1;
        n_vec++; if (hit_o !== 1'b0) begin n_err++; $display("FAIL partial_invalid got %0b want 0", hit_o); end
        pc_i = 16'h0800;
        feed(16'h0800, 16);
        n_vec++; if (ifetch_o !== 1'b1 || iaddr_o !== 16'h0810) begin n_err++; $display("FAIL pref2 got %0b/%h want 1/0810", ifetch_o, iaddr_o); end
        pc_i = 16'h0805; #1;
        n_vec++; if (instr_o !== 32'hC0DE0805) begin n_err++; $display("FAIL hit0805 got %h want C0DE0805", instr_o); end
        feed(16'h0810, 16);
        n_vec++; if (ifetch_o !== 1'b0) begin n_err++; $display("FAIL pref_done_ifetch got %0b want 0", ifetch_o); end
        pc_i = 16'h081F; #1;
        n_vec++; if (hit_o !== 1'b1 || instr_o !== 32'hC0DE081F) begin n_err++; $display("FAIL hit081F got %0b/%h want 1/C0DE081F", hit_o, instr_o); end
    endtask

    task automatic test_conflict();
        pc_i = 16'h0120; #1;
        n_vec++; if (instr_o !== 32'hC0DE0120) begin n_err++; $display("FAIL pre_evict got %h want C0DE0120", instr_o); end
        pc_i = 16'h0520;
        step();
        n_vec++; if (ifetch_o !== 1'b1 || iaddr_o !== 16'h0520) begin n_err++; $display("FAIL evict_fetch got %0b/%h want 1/0520", ifetch_o, iaddr_o); end
        feed(16'h0520, 16);
        n_vec++; if (iaddr_o !== 16'h0530) begin n_err++; $display("FAIL evict_pref got %h want 0530", iaddr_o); end
        feed(16'h0530, 16);
        pc_i = 16'h0120; #1;
        n_vec++; if (hit_o !== 1'b0) begin n_err++; $display("FAIL evicted_hit got %0b want 0", hit_o); end
        pc_i = 16'h0525; #1;
        n_vec++; if (instr_o !== 32'hC0DE0525) begin n_err++; $display("FAIL hit0525 got %h want C0DE0525", instr_o); end
        pc_i = 16'h053A; #1;
        n_vec++; if (instr_o !== 32'hC0DE053A) begin n_err++; $display("FAIL hit053A got %h want C0DE053A", instr_o); end
    endtask

    task automatic test_flush_wrap();
        pc_i    = 16'h0800;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        n_vec++; if (iabort_o !== 1'b0) begin n_err++; $display("FAIL idle_flush_abort got %0b want 0", iabort_o); end
        n_vec++; if (hit_o !== 1'b0) begin n_err++; $display("FAIL flushed0800 got %0b want 0", hit_o); end
        pc_i = 16'h0810; #1;
        n_vec++; if (hit_o !== 1'b0) begin n_err++; $display("FAIL flushed0810 got %0b want 0", hit_o); end
        pc_i = 16'h0525; #1;
        n_vec++; if (hit_o !== 1'b0) begin n_err++; $display("FAIL flushed0525 got %0b want 0", hit_o); end
        pc_i = 16'h0530; #1;
        n_vec++; if (hit_o !== 1'b0) begin n_err++; $display("FAIL flushed0530 got %0b want 0", hit_o); end
        pc_i = 16'h0800;
        step();
        n_vec++; if (ifetch_o !== 1'b1 || iaddr_o !== 16'h0800) begin n_err++; $display("FAIL refill0800 got %0b/%h want 1/0800", ifetch_o, iaddr_o); end
        feed(16'h0800, 2);
        flush_i  = 1'b1;
        iready_i = 1'b1;
        idata_i  = dval(16'h0802);
        step();
        flush_i  = 1'b0;
        iready_i = 1'b0;
        n_vec++; if (iabort_o !== 1'b1 || ifetch_o !== 1'b0) begin n_err++; $display("FAIL fill_flush got %0b/%0b want 1/0", iabort_o, ifetch_o); end
        pc_i = 16'hFFF0;
        step();
        n_vec++; if (iabort_o !== 1'b0 || iaddr_o !== 16'hFFF0) begin n_err++; $display("FAIL fetchFFF0 got %0b/%h want 0/FFF0", iabort_o, iaddr_o); end
        feed(16'hFFF0, 16);
        n_vec++; if (ifetch_o !== 1'b1 || iaddr_o !== 16'h0000) begin n_err++; $display("FAIL wrap_pref got %0b/%h want 1/0000", ifetch_o, iaddr_o); end
        pc_i = 16'hFFF5;
        feed(16'h0000, 3);
        pc_i = 16'h0001; #1;
        n_vec++; if (hit_o !== 1'b1 || instr_o !== 32'hC0DE0001) begin n_err++; $display("FAIL pref_early got %0b/%h want 1/C0DE0001", hit_o, instr_o); end
        pc_i = 16'h0003; #1;
        n_vec++; if (hit_o !== 1'b0) begin n_err++; $display("FAIL pref_bound got %0b want 0", hit_o); end
        pc_i = 16'hFFF5;
    endtask

    task automatic test_reset_mid_fill();
        pc_i = 16'h0123;
        step();
        n_vec++; if (iabort_o !== 1'b1) begin n_err++; $display("FAIL pref_abort got %0b want 1", iabort_o); end
        step();
        n_vec++; if (ifetch_o !== 1'b1 || iaddr_o !== 16'h0120) begin n_err++; $display("FAIL fetch0120 got %0b/%h want 1/0120", ifetch_o, iaddr_o); end
        feed(16'h0120, 7);
        reset_ni = 1'b0;
        step();
        n_vec++; if (iabort_o !== 1'b0 || ifetch_o !== 1'b0 || iaddr_o !== 16'h0000) begin n_err++; $display("FAIL mid_reset got %0b/%0b/%h want 0/0/0000", iabort_o, ifetch_o, iaddr_o); end
        n_vec++; if (hit_o !== 1'b0) begin n_err++; $display("FAIL mid_reset_hit got %0b want 0", hit_o); end
        reset_ni = 1'b1;
        step();
        n_vec++; if (iabort_o !== 1'b0 || ifetch_o !== 1'b1 || iaddr_o !== 16'h0120) begin n_err++; $display("FAIL post_reset got %0b/%0b/%h want 0/1/0120", iabort_o, ifetch_o, iaddr_o); end
        n_vec++; if (hit_o !== 1'b0) begin n_err++; $display("FAIL restart_count got %0b want 0", hit_o); end
        feed(16'h0120, 1);
        pc_i = 16'h0120; #1;
        n_vec++; if (hit_o !== 1'b1 || instr_o !== 32'hC0DE0120) begin n_err++; $display("FAIL word0 got %0b/%h want 1/C0DE0120", hit_o, instr_o); end
        pc_i = 16'h0121; #1;
        n_vec++; if (hit_o !== 1'b0) begin n_err++; $display("FAIL word1 got %0b want 0", hit_o); end
        pc_i = 16'h0120;
    endtask

    initial begin
        reset_ni = 1'b0;
        pc_i     = '0;
        flush_i  = 1'b0;
        iready_i = 1'b0;
        idata_i  = '0;
        test_reset();
        test_cold_miss();
        test_branch_abort();
        test_conflict();
        test_flush_wrap();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
